fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter and fetch sequencer for the 9-bit core; sits directly upstream of the control decoder and consumes its jump_en/branch_en each cycle.
- Holds a registered PC that addresses instruction ROM, plus a small target look-up table (LUT) indexed by instruction bits.
- Runs a start/halt handshake with the test harness and counts retired instructions.

Parameters:
- PC_W, 10, program counter width in bits; ROM depth is 2^PC_W.
- LUT_AW, 4, LUT index width; the LUT has 2^LUT_AW entries of PC_W bits each.
- START_ADDR, 0, PC value loaded on reset and on each Start.

Ports:
- CLK  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse that begins program execution.
- Stall  input  1  holds the PC and the counter this cycle (data-memory wait).
- Halt  input  1  decoder flag: the current instruction is halt.
- jump_en  input  1  decoder flag: absolute jump.
- branch_en  input  1  decoder flag: take a relative branch.
- Target_idx  input  LUT_AW  LUT index taken from the current instruction.
- Lut_we  input  1  LUT write enable; honoured only in IDLE.
- Lut_waddr  input  LUT_AW  LUT write index.
- Lut_wdata  input  PC_W  LUT write data.
- ProgCtr  output  PC_W  registered PC, drives the instruction ROM address.
- Running  output  1  high while in the RUN state.
- Done  output  1  high in the HALTED state.
- Instr_cnt  output  16  count of retired instructions.

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE, ProgCtr=START_ADDR, Done=0, Running=0, Instr_cnt=0.
  - All LUT entries cleared to 0.
  - Takes effect immediately, including mid-RUN.
- States: IDLE, RUN, HALTED. Running and Done are registered and equal (state==RUN) and (state==HALTED).
- IDLE:
  - A LUT write (Lut_we=1) updates the entry on the clock edge.
  - Start=1 -> RUN, ProgCtr=START_ADDR, Instr_cnt=0.
  - If Start and Lut_we are both high, the write still completes.
- RUN, evaluated each edge in priority order:
  1. Stall=1 -> hold ProgCtr and Instr_cnt; all flags are ignored.
  2. Halt=1 -> HALTED, ProgCtr held, Instr_cnt+1.
  3. jump_en=1 -> ProgCtr=LUT[Target_idx] (absolute).
  4. branch_en=1 -> ProgCtr = ProgCtr + LUT[Target_idx], with the entry treated as a two's-complement offset of PC_W bits; the result wraps mod 2^PC_W.
  5. Otherwise ProgCtr = ProgCtr + 1, wrapping from 2^PC_W-1 to 0.
  - Cases 3–5 each increment Instr_cnt.
  - Start and Lut_we are ignored in RUN.
- Instr_cnt saturates at 16'hFFFF; it never wraps.
- HALTED:
  - ProgCtr and Instr_cnt hold; Done=1; Lut_we is ignored.
  - Start=1 -> RUN, ProgCtr=START_ADDR, Instr_cnt=0, with Done and Running updating on the same edge.
- Latency: flags sampled at edge N select ProgCtr visible after edge N. The ROM/decoder path is combinational, so each instruction occupies exactly one cycle when not stalled.
- LUT read is combinational from Target_idx. A same-cycle write/read (IDLE only) returns the old value.

Test Plan:
- Reset and sequential fetch: pulse Reset_n low mid-run -> ProgCtr=0, Running=0, Done=0, Instr_cnt=0 immediately. Then Start, no flags for 5 cycles -> ProgCtr=5, Instr_cnt=5.
- Wrap: PC_W=10, load LUT[0]=10'h3FE, jump_en at PC=2 -> next PCs 3FE, 3FF, 000, 001.
- Backward branch: LUT[3]=10'h3FC (-4), branch_en at PC=20 -> PC=16. Next cycle jump_en and branch_en both high with LUT[1]=100, Target_idx=1 -> PC=100 (jump wins).
- Stall priority: Stall=1 with jump_en=1 for 3 cycles at PC=7 -> PC stays 7 and Instr_cnt is unchanged. Release Stall -> PC=LUT[idx].
- Halt/restart: Halt at PC=9 -> Done=1, Running=0, PC stays 9 for 10 cycles despite jump_en toggling. Start -> PC=0, Done=0, Instr_cnt=0.
- LUT protection: Lut_we in RUN writing LUT[2]=55, then jump via idx 2 -> PC equals the value written in IDLE (e.g. 40), not 55.

Source files
------------

// File: rtl/fetch_unit.sv
// Program-counter and fetch sequencer: PC register, jump/branch target LUT,
// start/halt handshake with the harness, and a saturating retired-instruction count.
module fetch_unit #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned LUT_AW     = 4,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Stall,
  input  logic              Halt,
  input  logic              jump_en,
  input  logic              branch_en,
  input  logic [LUT_AW-1:0] Target_idx,
  input  logic              Lut_we,
  input  logic [LUT_AW-1:0] Lut_waddr,
  input  logic [PC_W-1:0]   Lut_wdata,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              Running,
  output logic              Done,
  output logic [15:0]       Instr_cnt
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       cnt_q, cnt_d, cnt_sat;
  logic              running_q, done_q;
  logic              lut_wr;
  logic [PC_W-1:0]   lut_q [2**LUT_AW];
  logic [PC_W-1:0]   lut_rd;

  // Combinational read sees the pre-edge contents, so a same-cycle write returns old data.
  assign lut_rd  = lut_q[Target_idx];
  assign cnt_sat = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    lut_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        lut_wr = Lut_we;
        if (Start) begin
          state_d = RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!Stall) begin
          cnt_d = cnt_sat;
          if (Halt)           state_d = HALTED;
          else if (jump_en)   pc_d    = lut_rd;
          else if (branch_en) pc_d    = pc_q + lut_rd;  // two's-complement offset, wraps
          else                pc_d    = pc_q + PC_W'(1);
        end
      end
      HALTED: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      pc_q      <= START_PC;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      for (int unsigned i = 0; i < 2**LUT_AW; i++) begin
        lut_q[i[LUT_AW-1:0]] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == HALTED);
      if (lut_wr) lut_q[Lut_waddr] <= Lut_wdata;
    end
  end

  assign ProgCtr   = pc_q;
  assign Running   = running_q;
  assign Done      = done_q;
  assign Instr_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a reference model pushes expected outputs per
// clock, and they are popped and compared just after each rising edge.
module tb_fetch_unit;

  logic       CLK = 1'b0;
  logic       Reset_n;
  logic       Start, Stall, Halt, jump_en, branch_en, Lut_we;
  logic [3:0] Target_idx, Lut_waddr;
  logic [9:0] Lut_wdata;
  logic [9:0] ProgCtr;
  logic       Running, Done;
  logic [15:0] Instr_cnt;

  fetch_unit #(.PC_W(10), .LUT_AW(4), .START_ADDR(0)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .Halt(Halt),
    .jump_en(jump_en), .branch_en(branch_en), .Target_idx(Target_idx),
    .Lut_we(Lut_we), .Lut_waddr(Lut_waddr), .Lut_wdata(Lut_wdata),
    .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .Instr_cnt(Instr_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [9:0]  pc;
    logic        run;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_state;               // 0 idle, 1 run, 2 halted
  logic [9:0]  m_pc;
  logic [15:0] m_cnt;
  logic [9:0]  m_lut [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = '0;
    m_cnt   = '0;
    for (int i = 0; i < 16; i++) m_lut[i] = '0;
  endtask

  task automatic clr();
    Start = 0; Stall = 0; Halt = 0; jump_en = 0; branch_en = 0;
    Lut_we = 0; Target_idx = '0; Lut_waddr = '0; Lut_wdata = '0;
  endtask

  // Advance one clock with the currently driven inputs.
  task automatic tick();
    exp_t       e;
    logic [9:0] rd;
    rd = m_lut[Target_idx];
    case (m_state)
      0: begin
        if (Lut_we) m_lut[Lut_waddr] = Lut_wdata;
        if (Start) begin m_state = 1; m_pc = '0; m_cnt = '0; end
      end
      1: begin
        if (!Stall) begin
          if (Halt)           m_state = 2;
          else if (jump_en)   m_pc = rd;
          else if (branch_en) m_pc = m_pc + rd;
          else                m_pc = m_pc + 10'd1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end
      default: begin
        if (Start) begin m_state = 1; m_pc = '0; m_cnt = '0; end
      end
    endcase
    e.pc = m_pc; e.run = (m_state == 1); e.done = (m_state == 2); e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    check("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("pc", ProgCtr, e.pc);
      check("running", Running, e.run);
      check("done", Done, e.done);
      check("instr_cnt", Instr_cnt, e.cnt);
    end
  endtask

  task automatic lut_write(input logic [3:0] a, input logic [9:0] d);
    clr(); Lut_we = 1; Lut_waddr = a; Lut_wdata = d; tick();
  endtask

  task automatic jump(input logic [3:0] idx);
    clr(); jump_en = 1; Target_idx = idx; tick();
  endtask

  initial begin
    clr();
    model_reset();
    Reset_n = 0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_pc", ProgCtr, 0);
    check("rst_running", Running, 0);
    check("rst_done", Done, 0);
    check("rst_cnt", Instr_cnt, 0);
    Reset_n = 1;

    // Run briefly, then asynchronous reset mid-run.
    clr(); Start = 1; tick();
    clr(); repeat (3) tick();
    Reset_n = 0;
    #1;
    check("async_pc", ProgCtr, 0);
    check("async_running", Running, 0);
    check("async_done", Done, 0);
    check("async_cnt", Instr_cnt, 0);
    model_reset();
    #2 Reset_n = 1;
    @(posedge CLK); #1;

    lut_write(4'd0, 10'h3FE);
    lut_write(4'd1, 10'd100);
    lut_write(4'd2, 10'd40);
    lut_write(4'd3, 10'h3FC);
    lut_write(4'd4, 10'd2);
    lut_write(4'd6, 10'd20);
    lut_write(4'd7, 10'd7);
    lut_write(4'd8, 10'd9);

    // Start together with a LUT write: write must still land.
    clr(); Start = 1; Lut_we = 1; Lut_waddr = 4'd5; Lut_wdata = 10'd123; tick();
    check("start_pc", ProgCtr, 0);
    clr(); repeat (5) tick();
    check("seq_pc5", ProgCtr, 5);
    check("seq_cnt5", Instr_cnt, 5);

    // Wrap through 2^PC_W-1.
    jump(4'd4); check("to_pc2", ProgCtr, 2);
    jump(4'd0); check("wrap_3fe", ProgCtr, 10'h3FE);
    clr(); tick(); check("wrap_3ff", ProgCtr, 10'h3FF);
    tick();        check("wrap_000", ProgCtr, 10'h000);
    tick();        check("wrap_001", ProgCtr, 10'h001);

    // Backward branch then jump-over-branch priority.
    jump(4'd6); check("to_pc20", ProgCtr, 20);
    clr(); branch_en = 1; Target_idx = 4'd3; tick();
    check("branch_back", ProgCtr, 16);
    clr(); branch_en = 1; jump_en = 1; Target_idx = 4'd1; tick();
    check("jump_wins", ProgCtr, 100);

    // Stall overrides flags.
    jump(4'd7); check("to_pc7", ProgCtr, 7);
    clr(); Stall = 1; jump_en = 1; Halt = 1; Target_idx = 4'd5;
    repeat (3) tick();
    check("stall_hold", ProgCtr, 7);
    jump(4'd5); check("stall_release", ProgCtr, 123);

    // LUT is read-only in RUN.
    clr(); Lut_we = 1; Lut_waddr = 4'd2; Lut_wdata = 10'd55; tick();
    jump(4'd2); check("lut_protect", ProgCtr, 40);

    // Halt and restart.
    jump(4'd8); check("to_pc9", ProgCtr, 9);
    clr(); Halt = 1; tick();
    check("halt_done", Done, 1);
    check("halt_running", Running, 0);
    for (int i = 0; i < 10; i++) begin
      clr(); jump_en = i[0]; Target_idx = 4'd1; Lut_we = 1; Lut_waddr = 4'd1; Lut_wdata = 10'd3;
      tick();
    end
    check("halt_hold_pc", ProgCtr, 9);
    clr(); Start = 1; tick();
    check("restart_pc", ProgCtr, 0);
    check("restart_done", Done, 0);
    check("restart_cnt", Instr_cnt, 0);
    jump(4'd1); check("halt_lut_protect", ProgCtr, 100);

    // Random mix in RUN/HALTED.
    for (int i = 0; i < 80; i++) begin
      clr();
      Stall      = ($urandom_range(0, 3) == 0);
      Halt       = ($urandom_range(0, 11) == 0);
      jump_en    = 1'($urandom_range(0, 1));
      branch_en  = 1'($urandom_range(0, 1));
      Target_idx = 4'($urandom_range(0, 15));
      Lut_we     = 1'($urandom_range(0, 1));
      Lut_waddr  = 4'($urandom_range(0, 15));
      Lut_wdata  = 10'($urandom_range(0, 1023));
      Start      = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
